tsc_mc_control: RTL and testbench



---
 rtl/tsc_mc_control.sv | 255 +++++++++++++++++++++++++
 tb/tb_tsc_mc_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_mc_control.sv
// tsc_mc_control: multi-cycle IF/ID/EX/MEM/WB control FSM for the 16-bit TSC CPU.
// Drives every datapath select/enable, counts retired instructions and flags WWD/HLT.
module tsc_mc_control #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WORD_SIZE/4-1:0]   opcode_i,
  input  logic [5:0]               func_code_i,
  input  logic [1:0]               alu_compare_i,
  input  logic                     input_ready_i,
  input  logic                     ack_output_i,
  output logic [3:0]               alu_op_o,
  output logic                     reg_dst_o,
  output logic                     reg_write_o,
  output logic [1:0]               reg_write_src_o,
  output logic [1:0]               alu_src_a_o,
  output logic [1:0]               alu_src_b_o,
  output logic                     read_m_o,
  output logic                     write_m_o,
  output logic                     i_or_d_o,
  output logic                     ir_write_o,
  output logic                     mdr_write_o,
  output logic                     alu_out_write_o,
  output logic                     pc_write_o,
  output logic [1:0]               pc_src_o,
  output logic                     wwd_valid_o,
  output logic                     is_halted_o,
  output logic [CNT_W-1:0]         num_inst_o
);

  localparam int OPC_W = WORD_SIZE / 4;

  localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(4'd0);
  localparam logic [OPC_W-1:0] OP_BEQ = OPC_W'(4'd1);
  localparam logic [OPC_W-1:0] OP_BGZ = OPC_W'(4'd2);
  localparam logic [OPC_W-1:0] OP_BLZ = OPC_W'(4'd3);
  localparam logic [OPC_W-1:0] OP_ADI = OPC_W'(4'd4);
  localparam logic [OPC_W-1:0] OP_ORI = OPC_W'(4'd5);
  localparam logic [OPC_W-1:0] OP_LHI = OPC_W'(4'd6);
  localparam logic [OPC_W-1:0] OP_LWD = OPC_W'(4'd7);
  localparam logic [OPC_W-1:0] OP_SWD = OPC_W'(4'd8);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'd9);
  localparam logic [OPC_W-1:0] OP_JAL = OPC_W'(4'd10);
  localparam logic [OPC_W-1:0] OP_RTY = OPC_W'(4'd15);

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_LHI = 4'd8;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_inst_q, num_inst_d;
  logic             is_halted_q;

  logic [3:0] alu_op_s, alu_fn_s, i_op_s;
  logic [1:0] reg_write_src_s, alu_src_a_s, alu_src_b_s, pc_src_s;
  logic       reg_dst_s, reg_write_s, read_m_s, write_m_s, i_or_d_s, ir_write_s;
  logic       mdr_write_s, alu_out_write_s, pc_write_s, wwd_valid_s, taken_s;

  logic is_r_s, is_r_alu_s, is_i_alu_s, is_mem_s, is_branch_s;

  assign is_r_s      = (opcode_i == OP_RTY);
  assign is_r_alu_s  = is_r_s && (func_code_i[5:3] == 3'd0);
  assign is_i_alu_s  = (opcode_i == OP_ADI) || (opcode_i == OP_ORI) || (opcode_i == OP_LHI);
  assign is_mem_s    = (opcode_i == OP_LWD) || (opcode_i == OP_SWD);
  assign is_branch_s = (opcode_i == OP_BNE) || (opcode_i == OP_BEQ) ||
                       (opcode_i == OP_BGZ) || (opcode_i == OP_BLZ);
  assign alu_fn_s    = is_r_s ? {1'b0, func_code_i[2:0]} : i_op_s;

  // I-type ALU function and branch-taken decode
  always_comb begin
    i_op_s  = ALU_ADD;
    taken_s = 1'b0;
    case (opcode_i)
      OP_ORI:  i_op_s = ALU_ORR;
      OP_LHI:  i_op_s = ALU_LHI;
      default: i_op_s = ALU_ADD;
    endcase
    case (opcode_i)
      OP_BNE:  taken_s = (alu_compare_i != 2'b00);
      OP_BEQ:  taken_s = (alu_compare_i == 2'b00);
      OP_BGZ:  taken_s = (alu_compare_i == 2'b01);
      OP_BLZ:  taken_s = (alu_compare_i == 2'b10);
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state and control outputs
  always_comb begin
    state_d         = state_q;
    alu_op_s        = ALU_ADD;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    reg_write_src_s = 2'd0;
    alu_src_a_s     = 2'd0;
    alu_src_b_s     = 2'd0;
    read_m_s        = 1'b0;
    write_m_s       = 1'b0;
    i_or_d_s        = 1'b0;
    ir_write_s      = 1'b0;
    mdr_write_s     = 1'b0;
    alu_out_write_s = 1'b0;
    pc_write_s      = 1'b0;
    pc_src_s        = 2'd0;
    wwd_valid_s     = 1'b0;
    case (state_q)
      S_IF: begin
        read_m_s = 1'b1;
        if (input_ready_i) begin
          ir_write_s = 1'b1;
          state_d    = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        // PC+1+offset is precomputed into ALUOut for the branch in EX
        alu_src_a_s     = 2'd2;
        alu_src_b_s     = 2'd1;
        alu_out_write_s = 1'b1;
        if (is_r_alu_s || is_i_alu_s || is_mem_s || is_branch_s) begin
          state_d = S_EX;
        end else if (is_r_s && (func_code_i == FN_HLT)) begin
          state_d = S_HALT;
        end else begin
          state_d    = S_IF;
          pc_write_s = 1'b1;
          if ((opcode_i == OP_JMP) || (opcode_i == OP_JAL)) begin
            pc_src_s = 2'd2;
          end else if (is_r_s && ((func_code_i == FN_JPR) || (func_code_i == FN_JRL))) begin
            pc_src_s = 2'd3;
          end else begin
            pc_src_s = 2'd0;
          end
          if ((opcode_i == OP_JAL) || (is_r_s && (func_code_i == FN_JRL))) begin
            reg_write_s     = 1'b1;
            reg_write_src_s = 2'd2;
          end else begin
            reg_write_s = 1'b0;
          end
          wwd_valid_s = is_r_s && (func_code_i == FN_WWD);
        end
      end
      S_EX: begin
        if (is_branch_s) begin
          alu_op_s    = ALU_SUB;
          alu_src_b_s = ((opcode_i == OP_BNE) || (opcode_i == OP_BEQ)) ? 2'd0 : 2'd3;
          pc_write_s  = 1'b1;
          pc_src_s    = taken_s ? 2'd1 : 2'd0;
          state_d     = S_IF;
        end else if (is_mem_s) begin
          alu_src_b_s     = 2'd1;
          alu_out_write_s = 1'b1;
          state_d         = S_MEM;
        end else begin
          alu_op_s    = alu_fn_s;
          alu_src_b_s = is_r_s ? 2'd0 : 2'd1;
          state_d     = S_WB;
        end
      end
      S_MEM: begin
        i_or_d_s = 1'b1;
        if (opcode_i == OP_LWD) begin
          read_m_s = 1'b1;
          if (input_ready_i) begin
            mdr_write_s = 1'b1;
            state_d     = S_WB;
          end else begin
            state_d = S_MEM;
          end
        end else begin
          write_m_s = 1'b1;
          if (ack_output_i) begin
            pc_write_s = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_MEM;
          end
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        state_d     = S_IF;
        if (opcode_i == OP_LWD) begin
          reg_write_src_s = 2'd1;
        end else begin
          alu_op_s    = alu_fn_s;
          alu_src_b_s = is_r_s ? 2'd0 : 2'd1;
          reg_dst_s   = is_r_s;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Retire count: every PC update plus the HLT itself
  always_comb begin
    if (pc_write_s || ((state_q == S_ID) && (state_d == S_HALT))) begin
      num_inst_d = num_inst_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      num_inst_d = num_inst_q;
    end
  end

  // State, counter and halt flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IF;
      num_inst_q  <= {CNT_W{1'b0}};
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_inst_q  <= num_inst_d;
      is_halted_q <= (state_d == S_HALT);
    end
  end

  // Reset gating makes memory requests drop asynchronously
  assign alu_op_o        = {4{rst_ni}} & alu_op_s;
  assign reg_dst_o       = rst_ni & reg_dst_s;
  assign reg_write_o     = rst_ni & reg_write_s;
  assign reg_write_src_o = {2{rst_ni}} & reg_write_src_s;
  assign alu_src_a_o     = {2{rst_ni}} & alu_src_a_s;
  assign alu_src_b_o     = {2{rst_ni}} & alu_src_b_s;
  assign read_m_o        = rst_ni & read_m_s;
  assign write_m_o       = rst_ni & write_m_s;
  assign i_or_d_o        = rst_ni & i_or_d_s;
  assign ir_write_o      = rst_ni & ir_write_s;
  assign mdr_write_o     = rst_ni & mdr_write_s;
  assign alu_out_write_o = rst_ni & alu_out_write_s;
  assign pc_write_o      = rst_ni & pc_write_s;
  assign pc_src_o        = {2{rst_ni}} & pc_src_s;
  assign wwd_valid_o     = rst_ni & wwd_valid_s;
  assign is_halted_o     = is_halted_q;
  assign num_inst_o      = num_inst_q;

endmodule

// File: tb/tb_tsc_mc_control.sv
// Self-checking bench for tsc_mc_control: directed scenarios plus random instruction
// streams checked cycle by cycle against an instruction-level control model.
module tb_tsc_mc_control;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] wsrc;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       read_m;
    logic       write_m;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       aluout_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       wwd;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic [1:0] alu_compare;
  logic input_ready, ack_output;
  logic [3:0] alu_op;
  logic reg_dst, reg_write, read_m, write_m, i_or_d, ir_write, mdr_write;
  logic alu_out_write, pc_write, wwd_valid, is_halted;
  logic [1:0] reg_write_src, alu_src_a, alu_src_b, pc_src;
  logic [CNT_W-1:0] num_inst;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;
  ctl_t got;

  tsc_mc_control #(.WORD_SIZE(16), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .func_code_i(func_code),
    .alu_compare_i(alu_compare), .input_ready_i(input_ready), .ack_output_i(ack_output),
    .alu_op_o(alu_op), .reg_dst_o(reg_dst), .reg_write_o(reg_write),
    .reg_write_src_o(reg_write_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .read_m_o(read_m), .write_m_o(write_m), .i_or_d_o(i_or_d), .ir_write_o(ir_write),
    .mdr_write_o(mdr_write), .alu_out_write_o(alu_out_write), .pc_write_o(pc_write),
    .pc_src_o(pc_src), .wwd_valid_o(wwd_valid), .is_halted_o(is_halted), .num_inst_o(num_inst)
  );

  always #5 clk = ~clk;

  assign got = {alu_op, reg_dst, reg_write, reg_write_src, alu_src_a, alu_src_b, read_m,
                write_m, i_or_d, ir_write, mdr_write, alu_out_write, pc_write, pc_src, wwd_valid};

  task automatic chk_ctl(input string tag, input ctl_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; check at the falling edge, return just after the rising edge.
  task automatic cycle(input string tag, input ctl_t exp);
    @(negedge clk);
    chk_ctl(tag, exp);
    @(posedge clk);
    #1;
  endtask

  // One instruction from its first IF cycle to retirement (or to HALT entry).
  // abort: for SWD, reset is pulsed during the third MEM wait cycle.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic [1:0] cmp,
                           input int if_wait, input int mem_wait, input bit abort, input string tag);
    ctl_t c;
    bit rty, r_alu, i_alu, br, ld, st, taken;
    opcode = op; func_code = fn; alu_compare = cmp;
    rty   = (op == 4'd15);
    r_alu = rty && (fn < 6'd8);
    i_alu = (op >= 4'd4) && (op <= 4'd6);
    br    = (op <= 4'd3);
    ld    = (op == 4'd7);
    st    = (op == 4'd8);
    chk_val({tag, ":num_inst"}, 32'(num_inst), 32'(exp_cnt));
    chk_val({tag, ":halted"}, 32'(is_halted), 32'd0);

    for (int i = 0; i < if_wait; i++) begin
      input_ready = 1'b0; ack_output = 1'($urandom_range(0, 1));
      c = '0; c.read_m = 1'b1;
      cycle({tag, ":IF_wait"}, c);
    end
    input_ready = 1'b1; ack_output = 1'b0;
    c = '0; c.read_m = 1'b1; c.ir_write = 1'b1;
    cycle({tag, ":IF"}, c);

    input_ready = 1'($urandom_range(0, 1)); ack_output = 1'($urandom_range(0, 1));
    c = '0; c.src_a = 2'd2; c.src_b = 2'd1; c.aluout_write = 1'b1;
    if (rty && fn == 6'd29) begin
      cycle({tag, ":ID_hlt"}, c);
      exp_cnt = exp_cnt + 1'b1;
      return;
    end
    if (!(r_alu || i_alu || br || ld || st)) begin
      c.pc_write = 1'b1;
      if (op == 4'd9 || op == 4'd10) c.pc_src = 2'd2;
      else if (rty && (fn == 6'd25 || fn == 6'd26)) c.pc_src = 2'd3;
      if (op == 4'd10 || (rty && fn == 6'd26)) begin c.reg_write = 1'b1; c.wsrc = 2'd2; end
      c.wwd = rty && (fn == 6'd28);
      cycle({tag, ":ID_jump"}, c);
      exp_cnt = exp_cnt + 1'b1;
      return;
    end
    cycle({tag, ":ID"}, c);

    input_ready = 1'($urandom_range(0, 1)); ack_output = 1'($urandom_range(0, 1));
    c = '0;
    if (br) begin
      case (op)
        4'd0:    taken = (cmp != 2'd0);
        4'd1:    taken = (cmp == 2'd0);
        4'd2:    taken = (cmp == 2'd1);
        default: taken = (cmp == 2'd2);
      endcase
      c.alu_op = 4'd1; c.src_b = (op <= 4'd1) ? 2'd0 : 2'd3;
      c.pc_write = 1'b1; c.pc_src = taken ? 2'd1 : 2'd0;
      cycle({tag, ":EX_br"}, c);
      exp_cnt = exp_cnt + 1'b1;
      return;
    end
    if (ld || st) begin
      c.src_b = 2'd1; c.aluout_write = 1'b1;
      cycle({tag, ":EX_mem"}, c);
      for (int i = 0; i < mem_wait; i++) begin
        c = '0; c.iord = 1'b1;
        if (ld) begin
          input_ready = 1'b0; ack_output = 1'($urandom_range(0, 1)); c.read_m = 1'b1;
        end else begin
          input_ready = 1'($urandom_range(0, 1)); ack_output = 1'b0; c.write_m = 1'b1;
        end
        if (abort && st && i == 2) begin
          chk_val({tag, ":wr_req_before_rst"}, 32'(write_m), 32'd1);
          #2 rst_n = 1'b0;
          #1;
          chk_val({tag, ":wr_drop_async"}, 32'(write_m), 32'd0);
          chk_ctl({tag, ":rst_ctl"}, '0);
          chk_val({tag, ":rst_cnt"}, 32'(num_inst), 32'd0);
          @(posedge clk); #1;
          chk_ctl({tag, ":rst_held_ctl"}, '0);
          chk_val({tag, ":rst_halted"}, 32'(is_halted), 32'd0);
          input_ready = 1'b0; ack_output = 1'b0;
          rst_n = 1'b1;
          exp_cnt = '0;
          return;
        end
        cycle({tag, ":MEM_wait"}, c);
      end
      c = '0; c.iord = 1'b1;
      if (ld) begin
        input_ready = 1'b1; ack_output = 1'b0; c.read_m = 1'b1; c.mdr_write = 1'b1;
        cycle({tag, ":MEM_ld"}, c);
      end else begin
        input_ready = 1'b0; ack_output = 1'b1; c.write_m = 1'b1; c.pc_write = 1'b1;
        cycle({tag, ":MEM_st"}, c);
        exp_cnt = exp_cnt + 1'b1;
        return;
      end
    end else begin
      c.alu_op = rty ? {1'b0, fn[2:0]} : (op == 4'd4 ? 4'd0 : (op == 4'd5 ? 4'd3 : 4'd8));
      c.src_b  = rty ? 2'd0 : 2'd1;
      cycle({tag, ":EX_alu"}, c);
    end

    input_ready = 1'($urandom_range(0, 1)); ack_output = 1'($urandom_range(0, 1));
    c.read_m = 1'b0; c.iord = 1'b0; c.mdr_write = 1'b0; c.aluout_write = 1'b0;
    c.reg_write = 1'b1; c.pc_write = 1'b1; c.pc_src = 2'd0;
    if (ld) begin
      c = '0; c.reg_write = 1'b1; c.pc_write = 1'b1; c.wsrc = 2'd1;
    end else begin
      c.reg_dst = rty;
    end
    cycle({tag, ":WB"}, c);
    exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    logic [3:0] op;
    logic [5:0] fn;
    logic [15:0] add_inst;
    rst_n = 1'b0; opcode = 4'd0; func_code = 6'd0; alu_compare = 2'd0;
    input_ready = 1'b1; ack_output = 1'b1; exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_ctl("reset:ctl", '0);
    chk_val("reset:num_inst", 32'(num_inst), 32'd0);
    chk_val("reset:halted", 32'(is_halted), 32'd0);
    input_ready = 1'b0; ack_output = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_val("reset:readM_after_release", 32'(read_m), 32'd1);

    add_inst = 16'hF1C0;
    run_instr(add_inst[15:12], add_inst[5:0], 2'd0, 0, 0, 1'b0, "add_f1c0");
    run_instr(4'd7, 6'd0, 2'd0, 0, 3, 1'b0, "lwd_wait3");
    run_instr(4'd1, 6'd0, 2'd0, 0, 0, 1'b0, "beq_taken");
    run_instr(4'd1, 6'd0, 2'd1, 0, 0, 1'b0, "beq_not_taken");
    run_instr(4'd10, 6'd0, 2'd0, 0, 0, 1'b0, "jal");
    run_instr(4'd15, 6'd28, 2'd0, 0, 0, 1'b0, "wwd");
    c_wwd_after: chk_val("wwd:pulse_gone", 32'(wwd_valid), 32'd0);
    run_instr(4'd8, 6'd0, 2'd0, 1, 2, 1'b0, "swd_wait2");

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      fn = 6'($urandom_range(0, 63));
      if (op == 4'd15 && $urandom_range(0, 1) == 0) fn = 6'($urandom_range(0, 7));
      if (fn == 6'd29) fn = 6'd25;
      run_instr(op, fn, 2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0, $sformatf("rnd%0d_op%0d_fn%0d", n, op, fn));
    end

    run_instr(4'd8, 6'd0, 2'd0, 0, 5, 1'b1, "swd_reset");
    run_instr(4'd15, 6'd2, 2'd0, 0, 0, 1'b0, "and_after_reset");

    run_instr(4'd15, 6'd29, 2'd0, 0, 0, 1'b0, "hlt");
    for (int i = 0; i < 100; i++) begin
      input_ready = 1'($urandom_range(0, 1)); ack_output = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_ctl("halt:ctl", '0);
      chk_val("halt:halted", 32'(is_halted), 32'd1);
      chk_val("halt:num_inst", 32'(num_inst), 32'(exp_cnt));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
